pack_sequencer: RTL and testbench

- Controller that sequences the column packer for relational row projection.
- Per fetched 64-byte row line, issues one packer command per configured column (byte offset, byte size).
- Mirrors the packer fill level, gates issue so the packer's 128-byte window never overflows, and drives the writer handshake that generates `consumed`.
- At end of table, pads the partial last beat with zeros so it is written out, then reports done.

---
 rtl/pack_seq_pkg.sv | 20 ++
 rtl/pack_col_table.sv | 32 +++
 rtl/pack_sequencer.sv | 154 +++++++++++++++
 tb/tb_pack_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pack_seq_pkg.sv
// rtl/pack_seq_pkg.sv - shared types and constants for the column pack sequencer
package pack_seq_pkg;

  localparam int LINE_BYTES = 64;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LINE,
    ISSUE,
    FLUSH,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [5:0] offset;
    logic [6:0] width;
  } col_desc_t;

endpackage

// File: rtl/pack_col_table.sv
// rtl/pack_col_table.sv - column descriptor register file, one write port, one async read port
module pack_col_table
  import pack_seq_pkg::*;
#(
  parameter int MAX_COLS = 8,
  localparam int IDX_W = $clog2(MAX_COLS)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [5:0]       woffset,
  input  logic [6:0]       wwidth,
  input  logic [IDX_W-1:0] ridx,
  output logic [5:0]       roffset,
  output logic [6:0]       rwidth
);

  col_desc_t mem [MAX_COLS];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < MAX_COLS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[widx] <= '{offset: woffset, width: wwidth};
    end
  end

  assign roffset = mem[ridx].offset;
  assign rwidth  = mem[ridx].width;

endmodule

// File: rtl/pack_sequencer.sv
// rtl/pack_sequencer.sv - issues per-column packer commands per row line, mirrors packer fill,
// flushes the partial last beat and reports done.
module pack_sequencer
  import pack_seq_pkg::*;
#(
  parameter int MAX_COLS = 8,
  parameter int ROW_W = 32,
  localparam int IDX_W = $clog2(MAX_COLS),
  localparam int CNT_W = IDX_W + 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             cfg_start,
  input  logic [ROW_W-1:0] cfg_row_count,
  input  logic [CNT_W-1:0] cfg_col_count,
  input  logic             tbl_we,
  input  logic [IDX_W-1:0] tbl_idx,
  input  logic [5:0]       tbl_offset,
  input  logic [6:0]       tbl_width,
  input  logic             line_valid,
  output logic             line_ready,
  output logic             pk_valid,
  output logic [5:0]       pk_offset,
  output logic [15:0]      pk_size,
  output logic             pk_pad,
  output logic             pk_consumed,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic             busy,
  output logic             done,
  output logic [ROW_W-1:0] beats_written
);

  state_t           state, state_next;
  logic [7:0]       fill;
  logic [ROW_W-1:0] row, row_count;
  logic [IDX_W-1:0] col;
  logic [CNT_W-1:0] col_count;
  logic [5:0]       rd_offset;
  logic [6:0]       rd_width;
  logic             issue_ok, last_col, last_row, drain_empty;
  logic             start_acc, col_step;
  logic [5:0]       rem_after;

  pack_col_table #(.MAX_COLS(MAX_COLS)) u_table (
    .clock   (clock),
    .resetn  (resetn),
    .we      (tbl_we & ~busy),
    .widx    (tbl_idx),
    .woffset (tbl_offset),
    .wwidth  (tbl_width),
    .ridx    (col),
    .roffset (rd_offset),
    .rwidth  (rd_width)
  );

  assign wr_valid    = fill >= 8'(LINE_BYTES);
  assign pk_consumed = wr_valid & wr_ready;
  assign issue_ok    = ~wr_valid | pk_consumed;
  assign busy        = state != IDLE;
  assign last_col    = ({1'b0, col} + CNT_W'(1)) == col_count;
  assign last_row    = (row + ROW_W'(1)) >= row_count;
  // A consume removes a whole line, so the residue mod 64 depends only on what is added.
  assign rem_after   = fill[5:0] + rd_width[5:0];
  assign drain_empty = (fill == 8'd0) | ((fill == 8'(LINE_BYTES)) & pk_consumed);

  always_comb begin
    state_next = state;
    line_ready = 1'b0;
    pk_valid   = 1'b0;
    pk_offset  = 6'd0;
    pk_size    = 16'd0;
    pk_pad     = 1'b0;
    done       = 1'b0;
    start_acc  = 1'b0;
    col_step   = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          start_acc  = 1'b1;
          state_next = (cfg_row_count == '0) ? DONE : WAIT_LINE;
        end
      end
      WAIT_LINE: begin
        line_ready = 1'b1;
        if (line_valid) state_next = ISSUE;
      end
      ISSUE: begin
        if (issue_ok) begin
          pk_valid  = rd_width != 7'd0;
          pk_offset = rd_offset;
          pk_size   = {9'd0, rd_width};
          col_step  = 1'b1;
          if (last_col) begin
            if (!last_row)              state_next = WAIT_LINE;
            else if (rem_after != 6'd0) state_next = FLUSH;
            else                        state_next = DRAIN;
          end
        end
      end
      FLUSH: begin
        if (issue_ok) begin
          pk_valid   = 1'b1;
          pk_pad     = 1'b1;
          pk_size    = {9'd0, 7'(LINE_BYTES) - {1'b0, fill[5:0]}};
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_empty) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state         <= IDLE;
      fill          <= 8'd0;
      row           <= '0;
      row_count     <= '0;
      col           <= '0;
      col_count     <= '0;
      beats_written <= '0;
    end else begin
      state <= state_next;
      fill  <= fill + (pk_valid ? pk_size[7:0] : 8'd0)
                    - (pk_consumed ? 8'(LINE_BYTES) : 8'd0);
      if (pk_consumed) beats_written <= beats_written + ROW_W'(1);
      if (start_acc) begin
        row_count     <= cfg_row_count;
        col_count     <= (cfg_col_count == '0 || cfg_col_count > CNT_W'(MAX_COLS))
                         ? CNT_W'(MAX_COLS) : cfg_col_count;
        row           <= '0;
        col           <= '0;
        beats_written <= '0;
      end
      if (state == WAIT_LINE && line_valid) col <= '0;
      if (col_step) begin
        if (last_col) begin
          col <= '0;
          row <= row + ROW_W'(1);
        end else begin
          col <= col + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pack_sequencer.sv
// tb/tb_pack_sequencer.sv - directed self-checking bench for pack_sequencer
module tb_pack_sequencer;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_row_count = '0;
  logic [3:0]  cfg_col_count = '0;
  logic        tbl_we = 1'b0;
  logic [2:0]  tbl_idx = '0;
  logic [5:0]  tbl_offset = '0;
  logic [6:0]  tbl_width = '0;
  logic        line_valid = 1'b0;
  logic        line_ready;
  logic        pk_valid;
  logic [5:0]  pk_offset;
  logic [15:0] pk_size;
  logic        pk_pad;
  logic        pk_consumed;
  logic        wr_valid;
  logic        wr_ready = 1'b1;
  logic        busy;
  logic        done;
  logic [31:0] beats_written;

  pack_sequencer dut (
    .clock(clock), .resetn(resetn), .cfg_start(cfg_start),
    .cfg_row_count(cfg_row_count), .cfg_col_count(cfg_col_count),
    .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_offset(tbl_offset), .tbl_width(tbl_width),
    .line_valid(line_valid), .line_ready(line_ready),
    .pk_valid(pk_valid), .pk_offset(pk_offset), .pk_size(pk_size), .pk_pad(pk_pad),
    .pk_consumed(pk_consumed), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .busy(busy), .done(done), .beats_written(beats_written)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Independent fill model and event counters, sampled mid-cycle.
  logic mon_clr = 1'b1;
  int cyc = 0, fill_m = 0;
  int pv_cnt, pad_cnt, pad_size, cons_cnt, done_cnt, last_cons, done_cyc, viol, max_fill;

  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (!resetn) fill_m <= 0;
    else fill_m <= fill_m + (pk_valid ? int'(pk_size) : 0) - ((fill_m >= 64 && wr_ready) ? 64 : 0);
    if (mon_clr) begin
      pv_cnt <= 0; pad_cnt <= 0; pad_size <= 0; cons_cnt <= 0; done_cnt <= 0;
      last_cons <= 0; done_cyc <= 0; viol <= 0; max_fill <= 0;
    end else begin
      if (pk_valid) pv_cnt <= pv_cnt + 1;
      if (pk_valid && pk_pad) begin pad_cnt <= pad_cnt + 1; pad_size <= int'(pk_size); end
      if (fill_m >= 64 && wr_ready) begin cons_cnt <= cons_cnt + 1; last_cons <= cyc; end
      if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
      if (pk_valid && fill_m >= 64 && !wr_ready) viol <= viol + 1;
      if (fill_m > max_fill) max_fill <= fill_m;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic prog(input int idx, input int off, input int w);
    tbl_we = 1'b1; tbl_idx = 3'(idx); tbl_offset = 6'(off); tbl_width = 7'(w);
    step();
    tbl_we = 1'b0;
  endtask

  task automatic start_pass(input int rows, input int cols);
    mon_clr = 1'b1;
    cfg_row_count = 32'(rows); cfg_col_count = 4'(cols); cfg_start = 1'b1;
    step();
    cfg_start = 1'b0; mon_clr = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) step();
    step();
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    line_valid = 1'b1;
    step(); step();
    check("rst_busy", 32'(busy), 0);
    check("rst_pk_valid", 32'(pk_valid), 0);
    check("rst_wr_valid", 32'(wr_valid), 0);
    check("rst_line_ready", 32'(line_ready), 0);
    check("rst_done", 32'(done), 0);
    check("rst_beats", beats_written, 0);
    resetn = 1'b1;

    // Four 16-byte columns, two rows: exact beats, no flush.
    prog(0, 0, 16); prog(1, 16, 16); prog(2, 32, 16); prog(3, 48, 16);
    start_pass(2, 4);
    wait_done("t1");
    check("t1_beats", beats_written, 2);
    check("t1_pk_pulses", 32'(pv_cnt), 8);
    check("t1_flushes", 32'(pad_cnt), 0);
    check("t1_consumes", 32'(cons_cnt), 2);
    check("t1_done_lag", 32'(done_cyc - last_cons), 1);

    // 20 bytes per row x 10 rows = 200 bytes: 3 beats plus a 56-byte pad.
    prog(0, 0, 8); prog(1, 8, 4); prog(2, 20, 8);
    start_pass(10, 3);
    wait_done("t2");
    check("t2_beats", beats_written, 4);
    check("t2_pk_pulses", 32'(pv_cnt), 31);
    check("t2_flushes", 32'(pad_cnt), 1);
    check("t2_pad_size", 32'(pad_size), 56);
    check("t2_done_lag", 32'(done_cyc - last_cons), 1);

    // Same pass with the writer stalled at first.
    wr_ready = 1'b0;
    start_pass(10, 3);
    for (int i = 0; i < 20; i++) step();
    check("t3_stall_pk_valid", 32'(pk_valid), 0);
    check("t3_stall_wr_valid", 32'(wr_valid), 1);
    check("t3_stall_busy", 32'(busy), 1);
    wr_ready = 1'b1;
    wait_done("t3");
    check("t3_beats", beats_written, 4);
    check("t3_pk_pulses", 32'(pv_cnt), 31);
    check("t3_pad_size", 32'(pad_size), 56);
    check("t3_max_fill", 32'(max_fill), 68);
    check("t3_issue_violations", 32'(viol), 0);

    // Empty table pass.
    start_pass(0, 3);
    check("t4_done_next", 32'(done), 1);
    step();
    check("t4_done_clears", 32'(done), 0);
    check("t4_idle", 32'(busy), 0);
    check("t4_pk_pulses", 32'(pv_cnt), 0);
    check("t4_beats", beats_written, 0);

    // Zero-width column between two 32-byte columns.
    prog(0, 0, 32); prog(1, 0, 0); prog(2, 32, 32);
    start_pass(1, 3);
    wait_done("t5");
    check("t5_pk_pulses", 32'(pv_cnt), 2);
    check("t5_beats", beats_written, 1);
    check("t5_flushes", 32'(pad_cnt), 0);

    // Reset in the middle of issuing, with 40 bytes held.
    prog(0, 0, 20); prog(1, 20, 20); prog(2, 40, 20);
    start_pass(4, 3);
    check("t6_line_ready", 32'(line_ready), 1);
    step();
    check("t6_first_pk_valid", 32'(pk_valid), 1);
    check("t6_first_pk_size", 32'(pk_size), 20);
    step(); step();
    check("t6_col2_offset", 32'(pk_offset), 40);
    resetn = 1'b0;
    step();
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_pk_valid", 32'(pk_valid), 0);
    check("t6_rst_pk_size", 32'(pk_size), 0);
    check("t6_rst_wr_valid", 32'(wr_valid), 0);
    check("t6_rst_line_ready", 32'(line_ready), 0);
    check("t6_rst_beats", beats_written, 0);
    resetn = 1'b1;
    start_pass(1, 1);
    wait_done("t6_cleared_table");
    check("t6_cleared_pk_pulses", 32'(pv_cnt), 0);
    prog(0, 0, 16); prog(1, 16, 16); prog(2, 32, 16); prog(3, 48, 16);
    start_pass(2, 4);
    wait_done("t6_rerun");
    check("t6_rerun_beats", beats_written, 2);
    check("t6_rerun_pk_pulses", 32'(pv_cnt), 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
